// File: rtl/sysarr_pkg.sv
// Shared types and sizing helpers for the systolic array feeder.
// The state enum and step sizing are used by the feeder top.
package sysarr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT,
    DRAIN
  } feeder_state_t;

  function automatic int step_len(
    input int mul_len,
    input int add_len
  );
    return mul_len + add_len;
  endfunction

  function automatic int cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/sysarr_feed_fifo.sv
// Synchronous vector FIFO for the feeder.
// A push is dropped when full; a pop is ignored when empty.
module sysarr_feed_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         nRST,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit separates full from empty.
  assign full = (wptr[AW] != rptr[AW]) &&
                (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!nRST) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sysarr_input_feeder.sv
// Buffers input vectors and feeds them diagonally skewed into the
// systolic array rows, with step timing for the MAC grid.
module sysarr_input_feeder
  import sysarr_pkg::*;
#(
  parameter int N       = 4,
  parameter int WIDTH   = 16,
  parameter int MUL_LEN = 2,
  parameter int ADD_LEN = 3,
  parameter int DEPTH   = 4,
  localparam int STEP_LEN = step_len(MUL_LEN, ADD_LEN),
  localparam int CW       = cnt_width(STEP_LEN)
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_row,
  input  logic                 in_last,
  output logic [N*WIDTH-1:0]   row_value,
  output logic                 MAC_shift,
  output logic [CW-1:0]        count,
  output logic                 busy,
  output logic                 done
);

  localparam int DW  = N * WIDTH + 1;
  localparam int DCW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_LEN - 1);

  feeder_state_t state;
  feeder_state_t state_n;

  logic [CW-1:0]      cnt_n;
  logic [DCW-1:0]     drain_cnt;
  logic [DCW-1:0]     drain_cnt_n;
  logic               last_seen;
  logic               last_seen_n;
  logic               shift_n;
  logic               done_n;
  logic               pop;
  logic               zero_load;
  logic               load;
  logic               clear;
  logic               at_end;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DW-1:0]      fifo_q;
  logic [N*WIDTH-1:0] feed;
  logic               feed_last;

  sysarr_feed_fifo #(
    .W     (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nRST  (nRST),
    .push  (in_valid),
    .wdata ({in_last, in_row}),
    .pop   (pop),
    .rdata (fifo_q),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {feed_last, feed} = fifo_q;
  assign in_ready = !fifo_full;
  assign busy     = (state != IDLE);
  assign at_end   = (count == CNT_LAST);
  assign load     = pop || zero_load;

  always_comb begin
    state_n     = state;
    cnt_n       = count;
    drain_cnt_n = drain_cnt;
    last_seen_n = last_seen;
    done_n      = 1'b0;
    pop         = 1'b0;
    zero_load   = 1'b0;
    clear       = 1'b0;
    unique case (state)
      IDLE, WAIT: begin
        cnt_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        cnt_n = count + 1'b1;
        if (at_end) begin
          cnt_n = '0;
          if (last_seen) begin
            last_seen_n = 1'b0;
            if (N > 1) begin
              zero_load   = 1'b1;
              drain_cnt_n = DCW'(N - 1);
              state_n     = DRAIN;
            end else begin
              clear   = 1'b1;
              done_n  = 1'b1;
              state_n = IDLE;
            end
          end else if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end
      end
      DRAIN: begin
        cnt_n = count + 1'b1;
        if (at_end) begin
          cnt_n = '0;
          if (drain_cnt > DCW'(1)) begin
            zero_load   = 1'b1;
            drain_cnt_n = drain_cnt - 1'b1;
          end else begin
            clear   = 1'b1;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (pop && feed_last) last_seen_n = 1'b1;
    shift_n = load;
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state     <= IDLE;
      count     <= '0;
      drain_cnt <= '0;
      last_seen <= 1'b0;
      MAC_shift <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= cnt_n;
      drain_cnt <= drain_cnt_n;
      last_seen <= last_seen_n;
      MAC_shift <= shift_n;
      done      <= done_n;
    end
  end

  // Row r holds r+1 stages so it trails row 0 by r steps.
  for (genvar r = 0; r < N; r++) begin : g_row
    logic [WIDTH-1:0] chain [r+1];
    logic [WIDTH-1:0] elem;

    assign elem = zero_load ? '0 : feed[r*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
      if (!nRST || clear) begin
        for (int k = 0; k <= r; k++) chain[k] <= '0;
      end else if (load) begin
        chain[0] <= elem;
        for (int k = 1; k <= r; k++) chain[k] <= chain[k-1];
      end
    end

    assign row_value[r*WIDTH +: WIDTH] = chain[r];
  end

endmodule

// File: tb/tb_sysarr_input_feeder.sv
// Scoreboard bench for sysarr_input_feeder: random matrices in,
// skewed steps checked against a diagonal reference model.
module tb_sysarr_input_feeder;

  localparam int N        = 4;
  localparam int WIDTH    = 16;
  localparam int DEPTH    = 4;
  localparam int STEP_LEN = 5;
  localparam int CW       = 3;
  localparam int DW       = N * WIDTH;

  logic          clk = 1'b0;
  logic          nRST;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_row;
  logic          in_last;
  logic [DW-1:0] row_value;
  logic          MAC_shift;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;

  typedef struct {
    bit            is_done;
    bit            is_data;
    bit            first;
    bit            fixed_gap;
    logic [DW-1:0] rows;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mat[$];
  int            n_vec   = 0;
  int            n_bad   = 0;
  int            occ     = 0;
  int            n_steps = 0;

  always #5 clk = ~clk;

  sysarr_input_feeder dut (
    .clk       (clk),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .in_last   (in_last),
    .row_value (row_value),
    .MAC_shift (MAC_shift),
    .count     (count),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, req, $time);
    end
  endtask

  // Row k at step s carries element k of vector s-k, else zero.
  function automatic logic [DW-1:0] step_rows(input int s);
    logic [DW-1:0] r;
    logic [DW-1:0] v;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (s - k >= 0 && s - k < mat.size()) begin
        v = mat[s-k];
        r[k*WIDTH +: WIDTH] = v[k*WIDTH +: WIDTH];
      end
    end
    return r;
  endfunction

  task automatic record(input logic [DW-1:0] v, input bit l);
    exp_t e;
    int   k;
    mat.push_back(v);
    k           = mat.size();
    e.is_done   = 0;
    e.is_data   = 1;
    e.first     = (k == 1);
    e.fixed_gap = 0;
    e.rows      = step_rows(k - 1);
    exp_q.push_back(e);
    if (l) begin
      for (int s = k; s < k + N - 1; s++) begin
        e.is_data   = 0;
        e.first     = 0;
        e.fixed_gap = 1;
        e.rows      = step_rows(s);
        exp_q.push_back(e);
      end
      e.is_done   = 1;
      e.is_data   = 0;
      e.fixed_gap = 0;
      e.rows      = '0;
      exp_q.push_back(e);
      mat.delete();
    end
  endtask

  task automatic send(input logic [DW-1:0] v, input bit l,
                      input int gapmax);
    int t;
    t = 0;
    repeat ($urandom_range(0, gapmax)) @(negedge clk);
    in_valid = 1'b1;
    in_row   = v;
    in_last  = l;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
    end else begin
      occ++;
      record(v, l);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_row_value"}, row_value, 0);
    check({tag, "_mac_shift"}, MAC_shift, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  function automatic logic [DW-1:0] rand_vec();
    return {$urandom, $urandom};
  endfunction

  // Monitor: consumes one expectation per step pulse or done pulse.
  initial begin : monitor
    int            gap;
    logic [CW-1:0] pc;
    logic [DW-1:0] prev_rv;
    exp_t          e;
    gap     = 0;
    pc      = '0;
    prev_rv = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!nRST) begin
        gap     = 0;
        pc      = '0;
        prev_rv = '0;
        continue;
      end
      gap++;
      if (MAC_shift) begin
        n_steps++;
        check("shift_count", count, 0);
        check("shift_busy", busy, 1);
        if (exp_q.size() == 0) begin
          check("spurious_step", MAC_shift, 0);
        end else begin
          e = exp_q.pop_front();
          if (e.is_done) begin
            check("done_expected", done, 1);
          end else begin
            check("row_value", row_value, e.rows);
            if (e.fixed_gap)
              check("drain_gap", gap, STEP_LEN);
            else if (!e.first)
              check("step_gap_min", gap >= STEP_LEN, 1);
            if (e.is_data) occ--;
          end
        end
        gap = 0;
      end else if (done) begin
        check("row_clear", row_value, 0);
      end else begin
        check("row_hold", row_value, prev_rv);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", done, 0);
        end else begin
          e = exp_q.pop_front();
          if (!e.is_done) check("early_done", done, 0);
          else check("done_gap", gap, STEP_LEN);
        end
      end
      if (count != 0) check("count_step", count, pc + 1);
      check("in_ready", in_ready, occ < DEPTH);
      pc      = count;
      prev_rv = row_value;
    end
  end

  initial begin : driver
    int t;
    int base;
    nRST     = 1'b0;
    in_valid = 1'b0;
    in_row   = '0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    nRST = 1'b1;

    for (int m = 0; m < 14; m++) begin
      int k;
      int gm;
      k  = (m == 0) ? 1 : $urandom_range(1, 7);
      gm = (m % 3 == 0) ? 14 : ((m % 3 == 1) ? 0 : 3);
      for (int i = 0; i < k; i++) begin
        if (m == 0)
          send({16'd4, 16'd3, 16'd2, 16'd1}, 1'b1, 0);
        else
          send(rand_vec(), i == k - 1, gm);
      end
    end

    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", exp_q.size(), 0);

    // Abort a matrix mid-step: no done may follow.
    base = n_steps;
    for (int i = 0; i < 4; i++) send(rand_vec(), i == 3, 0);
    t = 0;
    while (!(n_steps == base + 3 && count == 3) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("abort_point", count, 3);
    nRST = 1'b0;
    @(negedge clk);
    exp_q.delete();
    mat.delete();
    occ = 0;
    check_reset("abort");
    nRST = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
